// File: rtl/exposure_fsm_gen_pkg.sv
// Shared types and constants for the exposure-meter controller.
package exposure_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEL,
    METER,
    LUT,
    DISP,
    ERR
  } state_e;

  typedef enum logic [1:0] {
    PB_NONE  = 2'b00,
    PB_SHORT = 2'b01,
    PB_LONG  = 2'b10,
    PB_XLONG = 2'b11
  } pb_e;

  localparam logic [3:0] GLYPH_RESET = 4'h8;
  localparam logic [3:0] GLYPH_BUSY  = 4'h2;
  localparam logic [3:0] GLYPH_ERR   = 4'hE;

endpackage

// File: rtl/exposure_fsm_gen_if.sv
// Luxmeter and flash request/ready bus seen by the exposure controller.
interface exposure_fsm_gen_if #(
  parameter int unsigned LUX_W  = 8,
  parameter int unsigned ADDR_W = 24
);
  logic              lux_valid;
  logic              lux_ready;
  logic [LUX_W-1:0]  lux_val;
  logic              fd_valid;
  logic              fd_ready;
  logic [7:0]        fd;
  logic [ADDR_W-1:0] fd_address;

  modport master (
    output lux_valid, fd_valid, fd_address,
    input  lux_ready, lux_val, fd_ready, fd
  );

  modport slave (
    input  lux_valid, fd_valid, fd_address,
    output lux_ready, lux_val, fd_ready, fd
  );
endinterface

// File: rtl/exposure_fsm_gen_hs_timer.sv
// Handshake wait timer: counts enabled cycles, expired flags the LIMIT-th wait cycle.
module hs_timer #(
  parameter int unsigned LIMIT = 1023
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int unsigned CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [CW-1:0] LAST = (LIMIT == 0) ? '0 : CW'(LIMIT - 1);

  logic [CW-1:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable && (count_q != LAST)) begin
      count_q <= count_q + 1'b1;
    end
  end

  // Counter saturates one short of LIMIT, so expiry coincides with the LIMIT-th cycle.
  assign expired = (LIMIT != 0) && enable && (count_q == LAST);
endmodule

// File: rtl/exposure_fsm_gen.sv
// Exposure-meter controller: setting selection, lux metering, flash LUT lookup, display.
module exposure_fsm_gen
  import exposure_pkg::*;
#(
  parameter int unsigned N_SET        = 3,
  parameter int unsigned SET_W        = 4,
  parameter int unsigned LUX_W        = 8,
  parameter int unsigned ADDR_W       = 24,
  parameter int unsigned RES_W        = 3,
  parameter int unsigned TIMEOUT      = 1023,
  parameter int unsigned AUTO_REMETER = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [1:0]                 pb_press,
  input  logic [SET_W-1:0]           enc_count,
  exposure_fsm_gen_if.master         bus,
  output logic [3:0]                 display_out,
  output logic [$clog2(N_SET+1)-1:0] display_sel,
  output logic                       err
);
  localparam int unsigned IW  = (N_SET > 1) ? $clog2(N_SET) : 1;
  localparam int unsigned DSW = $clog2(N_SET + 1);
  localparam int unsigned DW  = (AUTO_REMETER > 1) ? $clog2(AUTO_REMETER) : 1;
  localparam logic [DW-1:0] DWELL_LAST = (AUTO_REMETER == 0) ? '0 : DW'(AUTO_REMETER - 1);

  state_e state_q, state_d;
  pb_e    pb;

  logic [N_SET-1:0][SET_W-1:0] set_q;
  logic [N_SET-1:0]            visited_q;
  logic [N_SET-1:0]            visited_now;
  logic [IW-1:0]               idx_q, last_idx_q, idx_inc;
  logic [LUX_W-1:0]            lux_q;
  logic [RES_W-1:0]            res_q;
  logic [DW-1:0]               dwell_q;
  logic                        dwell_exp;
  logic                        state_change;
  logic                        wait_en;
  logic                        wait_exp;
  logic                        unused_fd_hi;

  assign pb           = pb_e'(pb_press);
  assign idx_inc      = (idx_q == IW'(N_SET - 1)) ? '0 : idx_q + 1'b1;
  assign visited_now  = visited_q | (N_SET'(1) << idx_q);
  assign state_change = (state_d != state_q);
  assign wait_en      = (state_q == METER) || (state_q == LUT);
  assign dwell_exp    = (AUTO_REMETER != 0) && (state_q == DISP) && (dwell_q == DWELL_LAST);
  assign unused_fd_hi = ^bus.fd[7:RES_W];

  hs_timer #(.LIMIT(TIMEOUT)) u_hs_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (state_change),
    .enable  (wait_en),
    .expired (wait_exp)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Ready is tested before the timer so a response on the expiry cycle still proceeds.
  always_comb begin
    state_d        = state_q;
    bus.lux_valid  = 1'b0;
    bus.fd_valid   = 1'b0;
    bus.fd_address = '0;
    display_out    = GLYPH_RESET;
    display_sel    = '0;
    err            = 1'b0;
    case (state_q)
      IDLE: state_d = SEL;
      SEL: begin
        display_sel = DSW'(idx_q);
        display_out = 4'(enc_count);
        if ((pb == PB_LONG) && (&visited_now)) state_d = METER;
      end
      METER: begin
        bus.lux_valid = 1'b1;
        display_sel   = DSW'(N_SET);
        display_out   = GLYPH_BUSY;
        if (bus.lux_ready)  state_d = LUT;
        else if (wait_exp)  state_d = ERR;
      end
      LUT: begin
        bus.fd_valid   = 1'b1;
        bus.fd_address = ADDR_W'({set_q, lux_q});
        display_sel    = DSW'(N_SET);
        display_out    = GLYPH_BUSY;
        if (bus.fd_ready)   state_d = DISP;
        else if (wait_exp)  state_d = ERR;
      end
      DISP: begin
        display_sel = DSW'(N_SET);
        display_out = 4'(res_q);
        case (pb)
          PB_SHORT:          state_d = METER;
          PB_LONG, PB_XLONG: state_d = SEL;
          default:           if (dwell_exp) state_d = METER;
        endcase
      end
      ERR: begin
        err         = 1'b1;
        display_sel = DSW'(N_SET);
        display_out = GLYPH_ERR;
        if (pb != PB_NONE) state_d = SEL;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      set_q      <= '0;
      visited_q  <= '0;
      idx_q      <= '0;
      last_idx_q <= '0;
      lux_q      <= '0;
      res_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          set_q     <= '0;
          visited_q <= '0;
          idx_q     <= '0;
        end
        SEL: begin
          set_q[idx_q]     <= enc_count;
          visited_q[idx_q] <= 1'b1;
          last_idx_q       <= idx_q;
          if (pb == PB_SHORT)      idx_q <= idx_inc;
          else if (pb == PB_XLONG) idx_q <= '0;
        end
        METER: if (bus.lux_ready) lux_q <= bus.lux_val;
        LUT:   if (bus.fd_ready)  res_q <= bus.fd[RES_W-1:0];
        DISP: begin
          if (pb == PB_LONG)       idx_q <= last_idx_q;
          else if (pb == PB_XLONG) idx_q <= '0;
        end
        ERR: if (pb != PB_NONE) idx_q <= '0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dwell_q <= '0;
    end else if (state_change) begin
      dwell_q <= '0;
    end else if ((state_q == DISP) && (dwell_q != DWELL_LAST)) begin
      dwell_q <= dwell_q + 1'b1;
    end
  end
endmodule

// File: tb/tb_exposure_fsm_gen.sv
// Scoreboard bench for exposure_fsm_gen: metering flow, timeouts, auto re-meter, reset.
module tb_exposure_fsm_gen;
  import exposure_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] pb_press = 2'b00;
  logic [3:0] enc_count = '0;
  logic [3:0] display_out;
  logic [1:0] display_sel;
  logic       err;

  int total = 0;
  int bad   = 0;
  logic [31:0] addr_q[$];
  logic [31:0] res_q[$];

  exposure_fsm_gen_if #(.LUX_W(8), .ADDR_W(24)) bus ();

  exposure_fsm_gen #(
    .N_SET(3), .SET_W(4), .LUX_W(8), .ADDR_W(24), .RES_W(3),
    .TIMEOUT(15), .AUTO_REMETER(20)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pb_press    (pb_press),
    .enc_count   (enc_count),
    .bus         (bus),
    .display_out (display_out),
    .display_sel (display_sel),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input pb_e code);
    pb_press = code;
    step();
    pb_press = PB_NONE;
  endtask

  task automatic chk_addr(input string tag);
    if (addr_q.size() == 0) chk(tag, 32'(bus.fd_address), 32'hDEAD_BEEF);
    else chk(tag, 32'(bus.fd_address), addr_q.pop_front());
  endtask

  task automatic chk_res(input string tag);
    if (res_q.size() == 0) chk(tag, 32'(display_out), 32'hDEAD_BEEF);
    else chk(tag, 32'(display_out), res_q.pop_front());
  endtask

  initial begin
    int n;
    bus.lux_ready = 1'b0;
    bus.lux_val   = '0;
    bus.fd_ready  = 1'b0;
    bus.fd        = '0;

    step();
    chk("rst_disp", 32'(display_out), 32'h8);
    chk("rst_sel", 32'(display_sel), 0);
    chk("rst_luxv", 32'(bus.lux_valid), 0);
    chk("rst_fdv", 32'(bus.fd_valid), 0);
    chk("rst_addr", 32'(bus.fd_address), 0);
    chk("rst_err", 32'(err), 0);

    rst = 1'b0;
    step();
    enc_count = 4'd5;
    #1;
    chk("sel0_sel", 32'(display_sel), 0);
    chk("sel0_disp", 32'(display_out), 5);

    press(PB_LONG);
    chk("early_long_sel", 32'(display_sel), 0);
    chk("early_long_luxv", 32'(bus.lux_valid), 0);

    press(PB_SHORT);
    chk("sel1_sel", 32'(display_sel), 1);
    enc_count = 4'd7;
    press(PB_SHORT);
    chk("sel2_sel", 32'(display_sel), 2);
    enc_count = 4'd2;
    #1;
    chk("sel2_disp", 32'(display_out), 2);

    press(PB_LONG);
    chk("meter_luxv", 32'(bus.lux_valid), 1);
    chk("meter_sel", 32'(display_sel), 3);
    chk("meter_disp", 32'(display_out), 4'h2);
    repeat (2) step();
    press(PB_SHORT);
    chk("meter_press_ignored", 32'(bus.lux_valid), 1);

    bus.lux_ready = 1'b1;
    bus.lux_val   = 8'h9C;
    addr_q.push_back({8'h00, 4'h0, 4'h2, 4'h7, 4'h5, 8'h9C});
    step();
    bus.lux_ready = 1'b0;
    chk("lut_luxv", 32'(bus.lux_valid), 0);
    chk("lut_fdv", 32'(bus.fd_valid), 1);
    chk_addr("lut_addr");
    addr_q.push_back({8'h00, 4'h0, 4'h2, 4'h7, 4'h5, 8'h9C});
    repeat (2) step();
    chk_addr("lut_addr_hold");

    bus.fd       = 8'hF5;
    bus.fd_ready = 1'b1;
    res_q.push_back(32'h5);
    step();
    bus.fd_ready = 1'b0;
    chk("disp_fdv", 32'(bus.fd_valid), 0);
    chk("disp_sel", 32'(display_sel), 3);
    chk_res("disp_res");

    n = 0;
    while (!bus.lux_valid && n < 40) begin
      step();
      n++;
    end
    chk("auto_remeter_cycles", 32'(n), 20);

    repeat (14) step();
    chk("edge_luxv", 32'(bus.lux_valid), 1);
    chk("edge_err", 32'(err), 0);
    bus.lux_ready = 1'b1;
    bus.lux_val   = 8'h3C;
    addr_q.push_back({8'h00, 4'h0, 4'h2, 4'h7, 4'h5, 8'h3C});
    step();
    bus.lux_ready = 1'b0;
    chk("edge_ready_wins_err", 32'(err), 0);
    chk("edge_ready_wins_fdv", 32'(bus.fd_valid), 1);
    chk_addr("edge_addr");

    bus.fd       = 8'h0B;
    bus.fd_ready = 1'b1;
    res_q.push_back(32'h3);
    step();
    bus.fd_ready = 1'b0;
    chk_res("disp_res2");

    enc_count = 4'd9;
    press(PB_LONG);
    chk("disp_long_sel", 32'(display_sel), 2);
    chk("disp_long_disp", 32'(display_out), 9);

    press(PB_LONG);
    n = 0;
    while (!err && n < 40) begin
      step();
      n++;
    end
    chk("timeout_cycles", 32'(n), 15);
    chk("err_disp", 32'(display_out), 4'hE);
    chk("err_sel", 32'(display_sel), 3);
    chk("err_luxv", 32'(bus.lux_valid), 0);
    chk("err_fdv", 32'(bus.fd_valid), 0);

    press(PB_SHORT);
    chk("err_exit_err", 32'(err), 0);
    chk("err_exit_sel", 32'(display_sel), 0);

    press(PB_SHORT);
    chk("xlong_pre_sel", 32'(display_sel), 1);
    press(PB_XLONG);
    chk("xlong_sel", 32'(display_sel), 0);

    press(PB_LONG);
    chk("rst_mid_pre", 32'(bus.lux_valid), 1);
    #3 rst = 1'b1;
    #1;
    chk("rst_mid_luxv", 32'(bus.lux_valid), 0);
    chk("rst_mid_disp", 32'(display_out), 4'h8);
    step();
    rst = 1'b0;
    step();
    chk("rst_mid_resume_sel", 32'(display_sel), 0);
    chk("rst_mid_resume_err", 32'(err), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
endmodule
